// File: rtl/data_bus_pkg.sv
// Shared definitions for the two-master data bus arbiter: bus widths,
// FSM state encoding, owner encoding and the latched command record.
package data_bus_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  localparam logic OWNER_M0 = 1'b0;
  localparam logic OWNER_M1 = 1'b1;

  typedef struct packed {
    logic              write;
    logic [BE_W-1:0]   be;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } bus_cmd_t;

endpackage

// File: rtl/bus_arb_select.sv
// Combinational winner selection: m0 has priority unless the guard is
// enabled and m1 has lost STARVE_LIMIT consecutive decisions.
module bus_arb_select
  import data_bus_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned CNT_W        = 4
) (
  input  logic             m0_req,
  input  logic             m1_req,
  input  logic [CNT_W-1:0] starve_cnt,
  input  logic             guard_en,
  output logic             grant_valid,
  output logic             grant_owner
);

  logic starved;

  // Pick the winner among the requesting masters.
  always_comb begin
    grant_valid = m0_req | m1_req;
    starved     = guard_en & m1_req & (starve_cnt == CNT_W'(STARVE_LIMIT));
    grant_owner = (m1_req & (~m0_req | starved)) ? OWNER_M1 : OWNER_M0;
  end

endmodule

// File: rtl/data_bus_arbiter.sv
// Two-master shared data bus arbiter with IDLE -> DRIVE -> RESP sequencing.
// Optional starvation guard for m1 enabled by macro BUS_ARB_STARVATION_GUARD_EN.
module data_bus_arbiter
  import data_bus_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic              core_clock,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_write,
  input  logic [BE_W-1:0]   m0_byte_enable,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [DATA_W-1:0] m0_write_data,
  input  logic              m1_req,
  input  logic              m1_write,
  input  logic [BE_W-1:0]   m1_byte_enable,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [DATA_W-1:0] m1_write_data,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_read_data,
  output logic              m0_stall,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_read_data,
  output logic              m1_stall,
  output logic [ADDR_W-1:0] bus_address,
  output logic [DATA_W-1:0] bus_write_data,
  output logic [BE_W-1:0]   bus_byte_enable,
  output logic              bus_read_enable,
  output logic              bus_write_enable,
  input  logic [DATA_W-1:0] bus_read_data,
  output logic              bus_owner
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;
  bus_cmd_t          cmd_q, cmd_d, m0_cmd, m1_cmd;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic [CNT_W-1:0]  starve_cnt;
  logic              guard_en, grant_valid, grant_owner;

`ifdef BUS_ARB_STARVATION_GUARD_EN
  logic [CNT_W-1:0] starve_q, starve_d;
  logic             decide;

  assign starve_cnt = starve_q;
  assign guard_en   = 1'b1;

  // Count consecutive decisions m1 loses while requesting; saturate at the limit.
  always_comb begin
    starve_d = starve_q;
    decide   = (state_q == ST_IDLE) || (state_q == ST_RESP);
    if (decide) begin
      if (m1_req && (grant_owner == OWNER_M0)) begin
        starve_d = (starve_q == CNT_W'(STARVE_LIMIT)) ? starve_q : starve_q + CNT_W'(1);
      end else begin
        starve_d = '0;
      end
    end
  end
`else
  assign starve_cnt = '0;
  assign guard_en   = 1'b0;
`endif

  bus_arb_select #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_W        (CNT_W)
  ) u_select (
    .m0_req      (m0_req),
    .m1_req      (m1_req),
    .starve_cnt  (starve_cnt),
    .guard_en    (guard_en),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );

  // Gather each master's command fields into one record for muxing.
  always_comb begin
    m0_cmd = '{write: m0_write, be: m0_byte_enable, addr: m0_address, wdata: m0_write_data};
    m1_cmd = '{write: m1_write, be: m1_byte_enable, addr: m1_address, wdata: m1_write_data};
  end

  // Next-state, command latch and read-data capture.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    cmd_d    = cmd_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    case (state_q)
      ST_IDLE, ST_RESP: begin
        if (grant_valid) begin
          state_d = ST_DRIVE;
          owner_d = grant_owner;
          cmd_d   = (grant_owner == OWNER_M1) ? m1_cmd : m0_cmd;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRIVE: begin
        state_d = ST_RESP;
        if (!cmd_q.write) begin
          if (owner_q == OWNER_M1) rdata1_d = bus_read_data;
          else                     rdata0_d = bus_read_data;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge core_clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      owner_q  <= OWNER_M0;
      cmd_q    <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
`ifdef BUS_ARB_STARVATION_GUARD_EN
      starve_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      cmd_q    <= cmd_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
`ifdef BUS_ARB_STARVATION_GUARD_EN
      starve_q <= starve_d;
`endif
    end
  end

  // Enables and acks decode from the state so reset clears them immediately.
  always_comb begin
    bus_address      = cmd_q.addr;
    bus_write_data   = cmd_q.wdata;
    bus_byte_enable  = cmd_q.be;
    bus_owner        = owner_q;
    bus_read_enable  = (state_q == ST_DRIVE) & ~cmd_q.write;
    bus_write_enable = (state_q == ST_DRIVE) &  cmd_q.write;
    m0_ack           = (state_q == ST_RESP) & (owner_q == OWNER_M0);
    m1_ack           = (state_q == ST_RESP) & (owner_q == OWNER_M1);
    m0_read_data     = rdata0_q;
    m1_read_data     = rdata1_q;
    m0_stall         = m0_req & ~m0_ack;
    m1_stall         = m1_req & ~m1_ack;
  end

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed scoreboard bench for data_bus_arbiter (STARVE_LIMIT = 3).
module tb_data_bus_arbiter;

  logic        core_clock = 1'b0;
  logic        reset;
  logic        m0_req, m0_write, m1_req, m1_write;
  logic [3:0]  m0_byte_enable, m1_byte_enable;
  logic [31:0] m0_address, m0_write_data, m1_address, m1_write_data;
  logic        m0_ack, m0_stall, m1_ack, m1_stall;
  logic [31:0] m0_read_data, m1_read_data;
  logic [31:0] bus_address, bus_write_data, bus_read_data;
  logic [3:0]  bus_byte_enable;
  logic        bus_read_enable, bus_write_enable, bus_owner;

  data_bus_arbiter #(.STARVE_LIMIT(3)) dut (
    .core_clock       (core_clock),
    .reset            (reset),
    .m0_req           (m0_req),
    .m0_write         (m0_write),
    .m0_byte_enable   (m0_byte_enable),
    .m0_address       (m0_address),
    .m0_write_data    (m0_write_data),
    .m1_req           (m1_req),
    .m1_write         (m1_write),
    .m1_byte_enable   (m1_byte_enable),
    .m1_address       (m1_address),
    .m1_write_data    (m1_write_data),
    .m0_ack           (m0_ack),
    .m0_read_data     (m0_read_data),
    .m0_stall         (m0_stall),
    .m1_ack           (m1_ack),
    .m1_read_data     (m1_read_data),
    .m1_stall         (m1_stall),
    .bus_address      (bus_address),
    .bus_write_data   (bus_write_data),
    .bus_byte_enable  (bus_byte_enable),
    .bus_read_enable  (bus_read_enable),
    .bus_write_enable (bus_write_enable),
    .bus_read_data    (bus_read_data),
    .bus_owner        (bus_owner)
  );

  always #5 core_clock = ~core_clock;

  typedef struct {
    logic        owner;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
  } xfer_t;

  xfer_t       exp_q[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] rd_exp0  = '0;
  logic [31:0] rd_exp1  = '0;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic set_master(input logic who, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [3:0] be);
    if (who) begin
      m1_write = wr; m1_address = addr; m1_write_data = wd; m1_byte_enable = be; m1_req = 1'b1;
    end else begin
      m0_write = wr; m0_address = addr; m0_write_data = wd; m0_byte_enable = be; m0_req = 1'b1;
    end
  endtask

  task automatic push_exp(input logic who, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [3:0] be, input logic [31:0] rd);
    xfer_t e;
    e.owner = who; e.wr = wr; e.addr = addr; e.wdata = wd; e.be = be; e.rdata = rd;
    exp_q.push_back(e);
  endtask

  // Wait for the next bus cycle, compare it with the scoreboard head, then check the ack.
  task automatic check_xfer(input bit hold);
    int    waited = 0;
    xfer_t e;
    do begin
      @(negedge core_clock);
      waited++;
    end while (!(bus_read_enable || bus_write_enable) && waited < 8);
    chk32("drive_latency", 32'(waited), 32'd1);
    if (!(bus_read_enable || bus_write_enable)) return;
    chk1("sb_nonempty", exp_q.size() != 0, 1'b1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    chk1("bus_owner", bus_owner, e.owner);
    chk1("bus_read_enable", bus_read_enable, ~e.wr);
    chk1("bus_write_enable", bus_write_enable, e.wr);
    chk32("bus_address", bus_address, e.addr);
    chk32("bus_write_data", bus_write_data, e.wdata);
    chk32("bus_byte_enable", 32'(bus_byte_enable), 32'(e.be));
    bus_read_data = e.wr ? ~e.addr : e.rdata;
    if (!hold) begin
      if (e.owner) m1_req = 1'b0;
      else         m0_req = 1'b0;
    end
    @(negedge core_clock);
    chk1("owner_ack", e.owner ? m1_ack : m0_ack, 1'b1);
    chk1("other_ack", e.owner ? m0_ack : m1_ack, 1'b0);
    chk1("resp_enables", bus_read_enable | bus_write_enable, 1'b0);
    if (!e.wr) begin
      if (e.owner) rd_exp1 = e.rdata;
      else         rd_exp0 = e.rdata;
    end
    chk32("m0_read_data", m0_read_data, rd_exp0);
    chk32("m1_read_data", m1_read_data, rd_exp1);
  endtask

  task automatic check_quiet(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge core_clock);
      chk1("quiet_enables", bus_read_enable | bus_write_enable, 1'b0);
      chk1("quiet_acks", m0_ack | m1_ack, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    m0_req = 1'b0; m0_write = 1'b0; m0_byte_enable = '0; m0_address = '0; m0_write_data = '0;
    m1_req = 1'b0; m1_write = 1'b0; m1_byte_enable = '0; m1_address = '0; m1_write_data = '0;
    bus_read_data = '0;
    m0_req = 1'b1;

    // Reset state; stall follows req during reset
    @(negedge core_clock);
    chk1("rst_read_enable", bus_read_enable, 1'b0);
    chk1("rst_write_enable", bus_write_enable, 1'b0);
    chk32("rst_bus_address", bus_address, 32'h0);
    chk1("rst_bus_owner", bus_owner, 1'b0);
    chk1("rst_acks", m0_ack | m1_ack, 1'b0);
    chk32("rst_m0_read_data", m0_read_data, 32'h0);
    chk1("rst_m0_stall", m0_stall, 1'b1);
    chk1("rst_m1_stall", m1_stall, 1'b0);
    m0_req = 1'b0;
    reset  = 1'b0;
    check_quiet(2);

    // Single m0 read, req held until ack
    set_master(1'b0, 1'b0, 32'h0000_1000, 32'h0, 4'hF);
    push_exp(1'b0, 1'b0, 32'h0000_1000, 32'h0, 4'hF, 32'hDEAD_BEEF);
    check_xfer(1'b1);
    chk1("ack_stall_low", m0_stall, 1'b0);
    m0_req = 1'b0;
    check_quiet(2);

    // Simultaneous writes: m0 first, m1 two cycles later
    set_master(1'b0, 1'b1, 32'h0000_0020, 32'h11, 4'hF);
    set_master(1'b1, 1'b1, 32'h0000_0024, 32'h22, 4'hF);
    push_exp(1'b0, 1'b1, 32'h0000_0020, 32'h11, 4'hF, 32'h0);
    push_exp(1'b1, 1'b1, 32'h0000_0024, 32'h22, 4'hF, 32'h0);
    check_xfer(1'b0);
    check_xfer(1'b0);
    check_quiet(2);

    // m1 pulses a request while m0 owns the bus, then withdraws before the decision
    set_master(1'b0, 1'b0, 32'h0000_0030, 32'h0, 4'h3);
    set_master(1'b1, 1'b0, 32'h0000_0034, 32'h0, 4'hF);
    push_exp(1'b0, 1'b0, 32'h0000_0030, 32'h0, 4'h3, 32'h3333_0000);
    check_xfer(1'b0);
    chk1("pending_m1_stall", m1_stall, 1'b1);
    m1_req = 1'b0;
    check_quiet(4);

    // Zero byte-enable write by m1 still runs as a normal transfer
    set_master(1'b1, 1'b1, 32'h0000_0044, 32'hA5A5_5A5A, 4'h0);
    push_exp(1'b1, 1'b1, 32'h0000_0044, 32'hA5A5_5A5A, 4'h0, 32'h0);
    check_xfer(1'b0);
    check_quiet(1);

    // Reset during DRIVE abandons the transfer
    set_master(1'b0, 1'b1, 32'h0000_0050, 32'h5555_5555, 4'hF);
    @(negedge core_clock);
    chk1("pre_rst_write_enable", bus_write_enable, 1'b1);
    reset = 1'b1;
    #1;
    chk1("mid_rst_write_enable", bus_write_enable, 1'b0);
    chk1("mid_rst_read_enable", bus_read_enable, 1'b0);
    chk32("mid_rst_bus_address", bus_address, 32'h0);
    chk32("mid_rst_m0_read_data", m0_read_data, 32'h0);
    chk1("mid_rst_m0_stall", m0_stall, 1'b1);
    rd_exp0 = '0;
    rd_exp1 = '0;
    m0_req = 1'b0;
    @(negedge core_clock);
    reset = 1'b0;
    check_quiet(2);
    set_master(1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'hF);
    push_exp(1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'hF, 32'hCAFE_F00D);
    check_xfer(1'b0);
    check_quiet(2);

    // Both masters hold requests continuously
    set_master(1'b0, 1'b0, 32'h0000_0100, 32'h0, 4'hF);
    set_master(1'b1, 1'b0, 32'h0000_0200, 32'h0, 4'hF);
`ifdef BUS_ARB_STARVATION_GUARD_EN
    push_exp(1'b0, 1'b0, 32'h0000_0100, 32'h0, 4'hF, 32'hA000_0000);
    push_exp(1'b0, 1'b0, 32'h0000_0100, 32'h0, 4'hF, 32'hA000_0001);
    push_exp(1'b0, 1'b0, 32'h0000_0100, 32'h0, 4'hF, 32'hA000_0002);
    push_exp(1'b1, 1'b0, 32'h0000_0200, 32'h0, 4'hF, 32'hB000_0000);
    push_exp(1'b0, 1'b0, 32'h0000_0100, 32'h0, 4'hF, 32'hA000_0003);
    check_xfer(1'b1);
    check_xfer(1'b1);
    check_xfer(1'b1);
    check_xfer(1'b0);
    check_xfer(1'b0);
`else
    for (int i = 0; i < 6; i++) begin
      push_exp(1'b0, 1'b0, 32'h0000_0100, 32'h0, 4'hF, 32'hA000_0000 + 32'(i));
    end
    for (int i = 0; i < 5; i++) check_xfer(1'b1);
    check_xfer(1'b0);
    chk1("starved_m1_stall", m1_stall, 1'b1);
    m1_req = 1'b0;
`endif
    check_quiet(3);
    chk32("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/data_bus_arbiter.md
DATA_BUS_ARBITER -- requirements
Module: data_bus_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 8, giving the number of consecutive lost arbitrations after which m1 is forced to win.
REQ-002 SHALL have ports core_clock  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high.
REQ-004 SHALL have, for each master x in {0,1}:
- mx_req  in  1  request
- mx_write  in  1  1=write, 0=read
- mx_byte_enable  in  4
- mx_address  in  32
- mx_write_data  in  32
REQ-005 SHALL have, for each x:
- mx_ack  out  1  one-cycle completion pulse
- mx_read_data  out  32  captured read data
- mx_stall  out  1  equals mx_req and not mx_ack
REQ-006 SHALL have the shared-bus ports:
- bus_address  out  32
- bus_write_data  out  32
- bus_byte_enable  out  4
- bus_read_enable  out  1
- bus_write_enable  out  1
- bus_read_data  in  32
- bus_owner  out  1  master currently driving

Function
REQ-007 SHALL implement the FSM IDLE -> DRIVE -> RESP, with RESP -> DRIVE on a pending request and RESP -> IDLE otherwise.
REQ-008 SHALL, in IDLE or RESP with any mx_req high, select a winner and register that master's write, byte_enable, address and write_data into the bus outputs, entering DRIVE next cycle.
REQ-009 SHALL assert exactly one of bus_read_enable or bus_write_enable only in DRIVE, for exactly one cycle per transfer.
REQ-010 SHALL sample bus_read_data at the end of DRIVE for reads, update the winner's mx_read_data, and pulse mx_ack in RESP.
- Latency from req sampled to ack is 2 cycles.
- Back-to-back throughput is one transfer per 2 cycles.
REQ-011 SHALL hold mx_read_data until the next read ack to the same master; a write ack SHALL leave it unchanged.
REQ-012 SHALL hold bus_address, bus_write_data, bus_byte_enable and bus_owner at their last values outside DRIVE.
REQ-013 SHALL give m0 priority over m1 when both request at the same decision point (subject to REQ-019).
REQ-014 SHALL complete and ack a transfer once it has been latched, even if mx_req drops during DRIVE.
REQ-015 SHALL ignore a request withdrawn before it has been latched.
REQ-016 SHALL perform a transfer with byte_enable = 0 normally, driving enables with zero byte lanes.
REQ-017 SHALL maintain a starvation counter that:
- increments at each decision m1 loses while requesting,
- saturates at STARVE_LIMIT,
- clears when m1 is granted or when m1_req is low at a decision point.

Reset
REQ-018 SHALL, while reset is high, immediately force:
- state IDLE
- all bus outputs 0
- bus_owner 0
- mx_ack 0
- mx_read_data 0
- starvation counter 0
An in-flight transfer SHALL be abandoned with no ack; mx_stall SHALL follow mx_req.

Configuration
REQ-019 SHALL, with macro BUS_ARB_STARVATION_GUARD_EN defined, grant m1 at the next decision once the starvation counter equals STARVE_LIMIT, overriding m0 priority.
REQ-020 SHALL, without BUS_ARB_STARVATION_GUARD_EN, use strict m0 priority, omit the counter entirely, and leave STARVE_LIMIT unused.

Structure
REQ-021 SHALL take from shared package data_bus_pkg:
- FSM state encoding (IDLE, DRIVE, RESP)
- owner encodings OWNER_M0 = 0 and OWNER_M1 = 1
- bus width constants (address 32, data 32, byte-enable 4)
REQ-022 SHALL place the winner decision (inputs: both req, starvation counter, guard flag) in combinational sub-module bus_arb_select; all sequential logic SHALL stay in data_bus_arbiter.

Verification
REQ-023 Bench SHALL cover a single read: m0 read at 0x0000_1000, bus_read_data = 0xDEAD_BEEF -> bus_read_enable pulses 1 cycle, m0_ack 2 cycles after req, m0_read_data = 0xDEAD_BEEF.
REQ-024 Bench SHALL cover simultaneous requests: m0 write 0x11 and m1 write 0x22 in the same cycle -> m0 DRIVE then m1 DRIVE, bus_owner 0 then 1, acks 2 cycles apart.
REQ-025 Bench SHALL cover starvation with guard enabled and STARVE_LIMIT = 3: m0_req held continuously, m1_req held -> m1 granted on the 4th decision; with guard disabled, m1 is never granted.
REQ-026 Bench SHALL cover reset mid-transfer: reset asserted during DRIVE -> enables 0 in the same cycle, no ack; after release, a new m1 read completes normally.
REQ-027 Bench SHALL cover request withdrawal: m1_req dropped in DRIVE -> m1_ack still pulses; a req pulsed and dropped while the other master owns the bus -> no transfer is issued.
